vending_txn_ctrl: RTL and testbench
===================================

Name: vending_txn_ctrl

Overview:
- Transaction controller for the vending machine. It owns the credit register and replaces the free-running money accumulator.
- Inputs are debounced one-pulse coin/cancel strobes and decoded keyboard drink selections (A/S/D/F → idx 0..3).
- It performs purchase, dispense hold and paced change return.
- Outputs are credit (to the money display and affordable-LED logic) and dispense/change strobes.

Parameters:
PRICE_0, 20, price of drink idx 0 (key A)
PRICE_1, 25, price of drink idx 1 (key S)
PRICE_2, 30, price of drink idx 2 (key D)
PRICE_3, 60, price of drink idx 3 (key F)
MAX_MONEY, 99, credit saturation value
DISPENSE_TICKS, 2, ticks spent in DISPENSE before change return

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous active-low reset
tick  in  1  one-cycle pacing strobe (1 s divider output)
coin_5  in  1  one-cycle strobe, 5 inserted
coin_10  in  1  one-cycle strobe, 10 inserted
coin_50  in  1  one-cycle strobe, 50 inserted
cancel  in  1  one-cycle strobe, abort and return credit
sel_valid  in  1  one-cycle strobe, drink selected
sel_idx  in  2  selected drink index
money  out  8  current credit, 0..MAX_MONEY
state  out  2  0=INSERT, 1=DISPENSE, 2=CHANGE
affordable  out  4  bit i set when money >= PRICE_i
dispense_valid  out  1  one-cycle strobe, drink released
dispense_idx  out  2  index of drink released, held until next dispense
change_valid  out  1  one-cycle strobe, change coin returned
change_amt  out  8  value of returned change, valid with change_valid
coin_reject  out  1  one-cycle strobe, coin ignored
sel_reject  out  1  one-cycle strobe, selection refused

Behaviour:
- Reset (rst=0, async): state=INSERT; money=0; dispense_idx=0; change_amt=0; all strobes=0; tick counter=0.
- All outputs are registered. Response appears the cycle after the input strobe. affordable is combinational from the money register.
- INSERT state:
  - Coin priority is 5 > 10 > 50; only one coin is credited per cycle, the others are dropped silently.
  - money <= min(money+coin, MAX_MONEY). Compute at 9 bits, no wrap. Saturation is not a reject.
  - Event priority when strobes coincide: cancel > sel_valid > coin.
  - cancel with money>0: → CHANGE. cancel with money=0: no-op.
  - sel_valid with money >= PRICE[sel_idx]: money -= price; dispense_valid=1; dispense_idx=sel_idx; tick count cleared; → DISPENSE.
  - sel_valid with money < price: sel_reject=1; stay in INSERT; money unchanged.
  - Any coin strobe coinciding with an accepted cancel or selection: coin not credited, coin_reject=1.
- DISPENSE state:
  - Count ticks. A tick in the same cycle as entry is not counted.
  - After DISPENSE_TICKS counted ticks: → CHANGE if money>0, else → INSERT.
- CHANGE state:
  - On each tick: change_amt = 10 if money>=10, else 5 if money>=5, else money (residue 1..4). change_valid=1; money -= change_amt.
  - When money reaches 0: → INSERT in the same cycle. The first change coin needs a tick strictly after entry.
- In DISPENSE and CHANGE, any coin strobe gives coin_reject=1, not credited. sel_valid gives sel_reject=1. cancel is ignored.
- Selecting with money exactly equal to price is accepted: money→0, DISPENSE, then directly INSERT.
- Reset mid-transaction: all state lost immediately, no change emitted.

Test Plan:
- Reset, then coin_50, coin_10, coin_5 on separate cycles → money 50, 60, 65; affordable=4'b1111.
- money=95, coin_10 → money=99 (saturated), no coin_reject; another coin_50 → still 99.
- money=65, sel idx1 (25) → dispense_valid, dispense_idx=1, money=40. After 2 ticks → CHANGE. Next 4 ticks → change_amt 10,10,10,10, then state=INSERT, money=0.
- money=20, sel idx3 (60) → sel_reject=1, money=20, state stays INSERT. cancel → CHANGE; ticks → change_amt 10,10; INSERT.
- money=99, cancel → change sequence 10×9, 5, 4, then money=0. coin_5 during CHANGE → coin_reject, money unaffected.
- Same cycle: sel_valid idx0 + coin_10 at money=20 → dispense accepted, money=0, coin_reject=1. Then assert rst=0 during DISPENSE → state=INSERT, money=0 immediately.

Source files
------------

// File: rtl/vending_txn_ctrl.sv
// vending_txn_ctrl: vending machine transaction controller.
// Owns the credit register. Handles coin insertion with saturation, drink
// purchase, a tick-paced dispense hold and tick-paced change return
// (10s first, then a 5, then the residue).
module vending_txn_ctrl #(
    parameter int unsigned PRICE_0        = 20,
    parameter int unsigned PRICE_1        = 25,
    parameter int unsigned PRICE_2        = 30,
    parameter int unsigned PRICE_3        = 60,
    parameter int unsigned MAX_MONEY      = 99,
    parameter int unsigned DISPENSE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       coin_50,
    input  logic       cancel,
    input  logic       sel_valid,
    input  logic [1:0] sel_idx,
    output logic [7:0] money,
    output logic [1:0] state,
    output logic [3:0] affordable,
    output logic       dispense_valid,
    output logic [1:0] dispense_idx,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       sel_reject
);

    typedef enum logic [1:0] {
        ST_INSERT   = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (DISPENSE_TICKS > 1) ? $clog2(DISPENSE_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DISPENSE_TICKS - 1);

    state_t           st;
    logic [CNT_W-1:0] tick_cnt;

    logic             coin_any;
    logic [8:0]       coin_val;
    logic [8:0]       money_sum;
    logic [7:0]       money_sat;
    logic [7:0]       price_sel;
    logic [7:0]       change_pick;

    assign state = st;

    // Price table and affordability flags, combinational from the credit register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        price_sel = 8'(PRICE_0);
        case (sel_idx)
            2'd0: price_sel = 8'(PRICE_0);
            2'd1: price_sel = 8'(PRICE_1);
            2'd2: price_sel = 8'(PRICE_2);
            2'd3: price_sel = 8'(PRICE_3);
            default: price_sel = 8'(PRICE_0);
        endcase
        affordable[0] = money >= 8'(PRICE_0);
        affordable[1] = money >= 8'(PRICE_1);
        affordable[2] = money >= 8'(PRICE_2);
        affordable[3] = money >= 8'(PRICE_3);
    end

    // Coin value with 5 > 10 > 50 priority, and saturating credit sum computed at 9 bits.
    always_comb begin
        coin_any = coin_5 | coin_10 | coin_50;
        coin_val = 9'd0;
        if (coin_5)       coin_val = 9'd5;
        else if (coin_10) coin_val = 9'd10;
        else if (coin_50) coin_val = 9'd50;
        money_sum = {1'b0, money} + coin_val;
        money_sat = (money_sum > 9'(MAX_MONEY)) ? 8'(MAX_MONEY) : money_sum[7:0];
    end

    // Next change coin: a 10 while possible, then a 5, then whatever residue is left.
    always_comb begin
        change_pick = money;
        if (money >= 8'd10)     change_pick = 8'd10;
        else if (money >= 8'd5) change_pick = 8'd5;
    end

    // Transaction FSM with registered credit, strobes and hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= ST_INSERT;
            tick_cnt       <= '0;
            money          <= 8'd0;
            dispense_valid <= 1'b0;
            dispense_idx   <= 2'd0;
            change_valid   <= 1'b0;
            change_amt     <= 8'd0;
            coin_reject    <= 1'b0;
            sel_reject     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; strobes default low
            // here and are raised for a single cycle by the branches below.
            dispense_valid <= 1'b0;
            change_valid   <= 1'b0;
            coin_reject    <= 1'b0;
            sel_reject     <= 1'b0;
            case (st)
                ST_INSERT: begin
                    if (cancel && money != 8'd0) begin
                        st          <= ST_CHANGE;
                        coin_reject <= coin_any;
                    end else if (sel_valid) begin
                        if (money >= price_sel) begin
                            money          <= money - price_sel;
                            dispense_valid <= 1'b1;
                            dispense_idx   <= sel_idx;
                            tick_cnt       <= '0;
                            st             <= ST_DISPENSE;
                            coin_reject    <= coin_any;
                        end else begin
                            // A refused selection does not block a coin in the same cycle.
                            sel_reject <= 1'b1;
                            if (coin_any) money <= money_sat;
                        end
                    end else if (coin_any) begin
                        money <= money_sat;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= coin_any;
                    sel_reject  <= sel_valid;
                    if (tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            st <= (money != 8'd0) ? ST_CHANGE : ST_INSERT;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= coin_any;
                    sel_reject  <= sel_valid;
                    if (tick) begin
                        change_valid <= 1'b1;
                        change_amt   <= change_pick;
                        money        <= money - change_pick;
                        if (money == change_pick) st <= ST_INSERT;
                    end
                end
                default: st <= ST_INSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// tb_vending_txn_ctrl: directed walk through the purchase, saturation, cancel
// and reset scenarios, followed by randomized strobes, all checked against a
// transaction-level model of the vending rules.
module tb_vending_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0, coin_50 = 1'b0;
    logic       cancel = 1'b0, sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'd0;
    logic [7:0] money, change_amt;
    logic [1:0] state, dispense_idx;
    logic [3:0] affordable;
    logic       dispense_valid, change_valid, coin_reject, sel_reject;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       tick, c5, c10, c50, cancel, sel;
        logic [1:0] idx;
    } stim_t;

    // Model: credit, phase (0 insert, 1 dispense hold, 2 paying change),
    // remaining hold ticks and the planned list of change coins.
    int m_money, m_phase, m_hold, m_didx;
    int m_change[$];
    int prices[4] = '{20, 25, 30, 60};
    logic e_dv, e_cv, e_cr, e_sr;
    int   e_camt;

    vending_txn_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick),
        .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .cancel(cancel), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .money(money), .state(state), .affordable(affordable),
        .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .sel_reject(sel_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_money = 0; m_phase = 0; m_hold = 0; m_didx = 0;
        m_change.delete();
        e_dv = 0; e_cv = 0; e_cr = 0; e_sr = 0; e_camt = 0;
    endtask

    // Split the whole credit into the coins it will be returned as.
    task automatic plan_change();
        int rest = m_money;
        m_change.delete();
        while (rest >= 10) begin m_change.push_back(10); rest -= 10; end
        if (rest >= 5) begin m_change.push_back(5); rest -= 5; end
        if (rest > 0) m_change.push_back(rest);
    endtask

    task automatic model_step(input stim_t s);
        int coin  = s.c5 ? 5 : s.c10 ? 10 : s.c50 ? 50 : 0;
        bit any   = s.c5 | s.c10 | s.c50;
        e_dv = 0; e_cv = 0; e_cr = 0; e_sr = 0;
        if (m_phase == 0) begin
            if (s.cancel && m_money > 0) begin
                plan_change(); m_phase = 2; e_cr = any;
            end else if (s.sel && m_money >= prices[s.idx]) begin
                m_money -= prices[s.idx]; m_didx = s.idx; e_dv = 1;
                m_hold = 2; m_phase = 1; e_cr = any;
            end else begin
                e_sr = s.sel;
                if (any) m_money = (m_money + coin > 99) ? 99 : m_money + coin;
            end
        end else begin
            e_cr = any; e_sr = s.sel;
            if (s.tick && m_phase == 1) begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_money > 0) begin plan_change(); m_phase = 2; end
                    else m_phase = 0;
                end
            end else if (s.tick) begin
                e_camt = m_change.pop_front(); e_cv = 1;
                m_money -= e_camt;
                if (m_change.size() == 0) m_phase = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] aff;
        for (int i = 0; i < 4; i++) aff[i] = (m_money >= prices[i]);
        check("money", 32'(money), 32'(m_money));
        check("state", 32'(state), 32'(m_phase));
        check("affordable", 32'(affordable), 32'(aff));
        check("dispense_valid", 32'(dispense_valid), 32'(e_dv));
        check("dispense_idx", 32'(dispense_idx), 32'(m_didx));
        check("change_valid", 32'(change_valid), 32'(e_cv));
        if (e_cv) check("change_amt", 32'(change_amt), 32'(e_camt));
        check("coin_reject", 32'(coin_reject), 32'(e_cr));
        check("sel_reject", 32'(sel_reject), 32'(e_sr));
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input stim_t s);
        @(negedge clk);
        tick = s.tick; coin_5 = s.c5; coin_10 = s.c10; coin_50 = s.c50;
        cancel = s.cancel; sel_valid = s.sel; sel_idx = s.idx;
        model_step(s);
        @(posedge clk);
        #1;
        tick = 0; coin_5 = 0; coin_10 = 0; coin_50 = 0; cancel = 0; sel_valid = 0;
        compare_all();
    endtask

    task automatic do_coin(input int v);
        stim_t s = '0;
        s.c5 = (v == 5); s.c10 = (v == 10); s.c50 = (v == 50);
        step(s);
    endtask

    task automatic do_sel(input int idx, input int coin);
        stim_t s = '0;
        s.sel = 1; s.idx = 2'(idx);
        s.c5 = (coin == 5); s.c10 = (coin == 10); s.c50 = (coin == 50);
        step(s);
    endtask

    task automatic do_ticks(input int n);
        stim_t s = '0;
        s.tick = 1;
        for (int i = 0; i < n; i++) step(s);
    endtask

    task automatic do_cancel();
        stim_t s = '0;
        s.cancel = 1;
        step(s);
    endtask

    initial begin
        stim_t s;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_money", 32'(money), 0);
        check("rst_state", 32'(state), 0);
        check("rst_strobes", 32'({dispense_valid, change_valid, coin_reject, sel_reject}), 0);
        check("rst_holds", 32'({dispense_idx, change_amt}), 0);
        @(negedge clk) rst = 1'b1;

        // Coins 50, 10, 5
        do_coin(50); check("plan_m50", 32'(money), 50);
        do_coin(10); check("plan_m60", 32'(money), 60);
        do_coin(5);  check("plan_m65", 32'(money), 65);
        check("plan_aff", 32'(affordable), 32'hF);

        // Purchase idx1 at 65, hold for 2 ticks, change 10 x4
        do_sel(1, 0);
        check("plan_dv", 32'(dispense_valid), 1);
        check("plan_didx", 32'(dispense_idx), 1);
        check("plan_m40", 32'(money), 40);
        do_ticks(2); check("plan_st_change", 32'(state), 2);
        for (int i = 0; i < 4; i++) begin
            do_ticks(1); check("plan_camt10", 32'(change_amt), 10);
        end
        check("plan_back_insert", 32'(state), 0);

        // Saturation at 99
        do_coin(50); do_coin(10); do_coin(10); do_coin(10); do_coin(10); do_coin(5);
        check("plan_m95", 32'(money), 95);
        do_coin(10); check("plan_sat99", 32'(money), 99);
        check("plan_sat_noreject", 32'(coin_reject), 0);
        do_coin(50); check("plan_sat99b", 32'(money), 99);

        // Cancel at 99: 10 x9, 5, 4, with a coin rejected mid-change
        do_cancel(); check("plan_cancel_st", 32'(state), 2);
        do_coin(5); check("plan_change_coinrej", 32'(coin_reject), 1);
        for (int i = 0; i < 9; i++) do_ticks(1);
        do_ticks(1); check("plan_camt5", 32'(change_amt), 5);
        do_ticks(1); check("plan_camt4", 32'(change_amt), 4);
        check("plan_m0", 32'(money), 0);

        // Unaffordable selection then cancel
        do_coin(10); do_coin(10);
        do_sel(3, 0);
        check("plan_selrej", 32'(sel_reject), 1);
        check("plan_m20", 32'(money), 20);
        do_cancel(); do_ticks(2);
        check("plan_cancel_done", 32'(state), 0);

        // Exact-price purchase with coincident coin, then reset during DISPENSE
        do_coin(10); do_coin(10);
        do_sel(0, 10);
        check("plan_exact_cr", 32'(coin_reject), 1);
        check("plan_exact_m0", 32'(money), 0);
        check("plan_exact_st", 32'(state), 1);
        @(negedge clk) rst = 1'b0;
        #1;
        check("plan_arst_state", 32'(state), 0);
        check("plan_arst_money", 32'(money), 0);
        model_reset();
        @(negedge clk) rst = 1'b1;

        // Exact price with no hold-time ticks lost: after DISPENSE go straight to INSERT
        do_coin(50); do_coin(10);
        do_sel(3, 0); do_ticks(2);
        check("plan_exact_insert", 32'(state), 0);

        // Randomized strobes against the model
        for (int n = 0; n < 1500; n++) begin
            s = '0;
            s.tick   = ($urandom_range(0, 2) == 0);
            s.c5     = ($urandom_range(0, 5) == 0);
            s.c10    = ($urandom_range(0, 5) == 0);
            s.c50    = ($urandom_range(0, 7) == 0);
            s.cancel = ($urandom_range(0, 24) == 0);
            s.sel    = ($urandom_range(0, 7) == 0);
            s.idx    = 2'($urandom_range(0, 3));
            step(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
